// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: valid/ready request and response channels, fixed LATENCY.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip memory and respond with resp_err=1, resp_rdata=0.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} stateT;

  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  stateT                 state;
  logic [3:0]            latCount;
  logic                  capWrite;
  logic [ADDR_WIDTH-1:0] capIndex;
  logic [31:0]           capWdata;
  logic                  capMisalign;
  logic                  offsetTrap;
  logic                  memWrite;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic                  unusedAddrBits;

  // Upper address bits wrap away; the byte offset only matters with the trap enabled.
  assign unusedAddrBits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

`ifdef MISALIGN_TRAP_EN
  assign offsetTrap = (req_addr[1:0] != 2'd0);
`else
  assign offsetTrap = 1'b0;
`endif

  // Memory write strobe: aligned store reaching its access edge in WAIT.
  always_comb begin
    memWrite = 1'b0;
    if ((state == WAIT) && (latCount == 4'd0) && capWrite && !capMisalign) begin
      memWrite = 1'b1;
    end else begin
      memWrite = 1'b0;
    end
  end

  // Storage array, deliberately not reset; reset forces IDLE so a pending store is dropped.
  always_ff @(posedge clock) begin
    if (memWrite) begin
      mem[capIndex] <= capWdata;
    end
  end

  // Request capture, latency countdown and registered handshake outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      latCount    <= 4'd0;
      capWrite    <= 1'b0;
      capIndex    <= '0;
      capWdata    <= 32'd0;
      capMisalign <= 1'b0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            capWrite    <= req_write;
            capIndex    <= req_addr[ADDR_WIDTH+1:2];
            capWdata    <= req_wdata;
            capMisalign <= offsetTrap;
            latCount    <= LAT_INIT;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (latCount == 4'd0) begin
            resp_valid <= 1'b1;
            state      <= RESP;
            if (capMisalign) begin
              resp_rdata <= 32'd0;
              resp_err   <= 1'b1;
            end else if (capWrite) begin
              resp_rdata <= capWdata;
              resp_err   <= 1'b0;
            end else begin
              resp_rdata <= mem[capIndex];
              resp_err   <= 1'b0;
            end
          end else begin
            latCount <= latCount - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          latCount   <= 4'd0;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
